// File: rtl/universal_register.sv
// universal_register: WIDTH-bit register with enable, eight modes and a saturating shift counter
module universal_register #(
    parameter int WIDTH = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       serial_in,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_n,
    output logic                       serial_out_msb,
    output logic                       serial_out_lsb,
    output logic [$clog2(WIDTH+1)-1:0] shift_count,
    output logic                       shift_done
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
    logic [WIDTH-1:0] q_next;
    logic [CW-1:0]    count_next;
    logic             is_shift;
    logic             is_restart;
    always_comb begin
        q_next = q;
        case (mode)
            3'b001: q_next = d;
            3'b010: q_next = {q[WIDTH-2:0], serial_in};
            3'b011: q_next = {serial_in, q[WIDTH-1:1]};
            3'b100: q_next = {q[WIDTH-2:0], q[WIDTH-1]};
            3'b101: q_next = {q[0], q[WIDTH-1:1]};
            3'b110: q_next = '0;
            3'b111: q_next = ~q;
            default: q_next = q;
        endcase
    end
    assign is_shift   = mode[2] ^ mode[1];
    assign is_restart = (mode == 3'b001) || (mode == 3'b110);
    assign count_next = is_restart ? '0 :
                        (is_shift && shift_count != FULL) ? shift_count + 1'b1 : shift_count;
    always_ff @(posedge clock) begin
        if (reset) begin
            q           <= RESET_VALUE;
            shift_count <= '0;
        end else if (enable) begin
            q           <= q_next;
            shift_count <= count_next;
        end
    end
    assign q_n            = ~q;
    assign serial_out_msb = q[WIDTH-1];
    assign serial_out_lsb = q[0];
    assign shift_done     = shift_count == FULL;
endmodule

// File: tb/tb_universal_register.sv
// tb_universal_register: vector table plus scoreboard checks for universal_register
module tb_universal_register;
    logic       clock = 0;
    logic       reset, enable, serial_in;
    logic [2:0] mode;
    logic [7:0] d, q, q_n;
    logic       serial_out_msb, serial_out_lsb, shift_done;
    logic [3:0] shift_count;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] m;
        logic [7:0] d;
        logic       sin;
        logic [7:0] eq;
        logic [3:0] ec;
    } vec_t;

    typedef struct {
        logic [7:0] eq;
        logic [3:0] ec;
        logic       edone;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    universal_register #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut (
        .clock(clock), .reset(reset), .enable(enable), .mode(mode), .d(d),
        .serial_in(serial_in), .q(q), .q_n(q_n), .serial_out_msb(serial_out_msb),
        .serial_out_lsb(serial_out_lsb), .shift_count(shift_count), .shift_done(shift_done)
    );

    always #5 clock = ~clock;

    task automatic add(input logic rst, input logic en, input logic [2:0] m, input logic [7:0] dv,
                       input logic sin, input logic [7:0] eq, input logic [3:0] ec);
        vec_t v;
        v.rst = rst; v.en = en; v.m = m; v.d = dv; v.sin = sin; v.eq = eq; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [2:0] m, input logic [7:0] dv,
                        input logic sin, input logic [7:0] eq, input logic [3:0] ec, input logic edone);
        exp_t e;
        reset = rst; enable = en; mode = m; d = dv; serial_in = sin;
        e.eq = eq; e.ec = ec; e.edone = edone;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        cmp("q", q, e.eq);
        cmp("q_n", q_n, ~e.eq);
        cmp("msb", {7'd0, serial_out_msb}, {7'd0, e.eq[7]});
        cmp("lsb", {7'd0, serial_out_lsb}, {7'd0, e.eq[0]});
        cmp("shift_count", {4'd0, shift_count}, {4'd0, e.ec});
        cmp("shift_done", {7'd0, shift_done}, {7'd0, e.edone});
    endtask

    initial begin
        logic [7:0] r;
        reset = 1; enable = 1; mode = 3'b001; d = 8'hFF; serial_in = 0;
        add(1, 1, 3'b001, 8'hFF, 0, 8'hA5, 0);
        add(1, 1, 3'b001, 8'hFF, 0, 8'hA5, 0);
        add(0, 1, 3'b001, 8'h3C, 0, 8'h3C, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 3'(i), 8'hFF, 1, 8'h3C, 0);
        add(0, 1, 3'b001, 8'h81, 0, 8'h81, 0);
        add(0, 1, 3'b010, 8'h00, 0, 8'h02, 1);
        add(0, 1, 3'b001, 8'h81, 0, 8'h81, 0);
        add(0, 1, 3'b011, 8'h00, 1, 8'hC0, 1);
        add(0, 1, 3'b001, 8'h81, 0, 8'h81, 0);
        add(0, 1, 3'b100, 8'h00, 1, 8'h03, 1);
        add(0, 1, 3'b001, 8'h81, 0, 8'h81, 0);
        add(0, 1, 3'b101, 8'h00, 0, 8'hC0, 1);
        add(0, 1, 3'b001, 8'h96, 0, 8'h96, 0);
        add(0, 1, 3'b100, 8'h00, 0, 8'h2D, 1);
        add(0, 1, 3'b100, 8'h00, 0, 8'h5A, 2);
        add(0, 1, 3'b100, 8'h00, 0, 8'hB4, 3);
        add(0, 1, 3'b100, 8'h00, 0, 8'h69, 4);
        add(0, 1, 3'b100, 8'h00, 0, 8'hD2, 5);
        add(0, 1, 3'b100, 8'h00, 0, 8'hA5, 6);
        add(0, 1, 3'b100, 8'h00, 0, 8'h4B, 7);
        add(0, 1, 3'b100, 8'h00, 0, 8'h96, 8);
        add(0, 1, 3'b001, 8'hFF, 0, 8'hFF, 0);
        add(0, 1, 3'b010, 8'h00, 0, 8'hFE, 1);
        add(0, 1, 3'b010, 8'h00, 0, 8'hFC, 2);
        add(0, 1, 3'b010, 8'h00, 0, 8'hF8, 3);
        add(0, 1, 3'b010, 8'h00, 0, 8'hF0, 4);
        add(0, 1, 3'b010, 8'h00, 0, 8'hE0, 5);
        add(0, 1, 3'b010, 8'h00, 0, 8'hC0, 6);
        add(0, 1, 3'b010, 8'h00, 0, 8'h80, 7);
        add(0, 1, 3'b010, 8'h00, 0, 8'h00, 8);
        add(0, 1, 3'b010, 8'h00, 1, 8'h01, 8);
        add(0, 1, 3'b010, 8'h00, 0, 8'h02, 8);
        add(0, 1, 3'b111, 8'h00, 0, 8'hFD, 8);
        add(0, 1, 3'b000, 8'h55, 1, 8'hFD, 8);
        add(0, 1, 3'b110, 8'h55, 1, 8'h00, 0);
        add(0, 1, 3'b111, 8'h00, 0, 8'hFF, 0);
        add(0, 1, 3'b001, 8'hF0, 0, 8'hF0, 0);
        add(0, 1, 3'b011, 8'h00, 0, 8'h78, 1);
        add(0, 1, 3'b011, 8'h00, 0, 8'h3C, 2);
        add(0, 1, 3'b011, 8'h00, 0, 8'h1E, 3);
        add(1, 1, 3'b010, 8'h00, 1, 8'hA5, 0);
        add(0, 1, 3'b010, 8'h00, 0, 8'h4A, 1);
        add(0, 0, 3'b110, 8'h00, 0, 8'h4A, 1);
        add(0, 1, 3'b111, 8'h00, 0, 8'hB5, 1);
        foreach (vecs[i])
            step(vecs[i].rst, vecs[i].en, vecs[i].m, vecs[i].d, vecs[i].sin,
                 vecs[i].eq, vecs[i].ec, vecs[i].ec == 4'd8);
        // twelve rotate-rights equal four, i.e. a nibble swap, with the count pinned at 8
        for (int t = 0; t < 3; t++) begin
            r = 8'($urandom);
            step(0, 1, 3'b001, r, 0, r, 0, 0);
            for (int k = 1; k <= 12; k++) begin
                step(0, 1, 3'b101, 8'h00, 0, (r >> (k % 8)) | (r << (8 - (k % 8))),
                     k >= 8 ? 4'd8 : 4'(k), k >= 8);
            end
            cmp("nibble_swap", q, {r[3:0], r[7:4]});
        end
        // reset on a saturated register clears done immediately after the edge
        step(1, 0, 3'b100, 8'h00, 0, 8'hA5, 0, 0);
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        checks++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
